// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and the core's load/store port.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int unsigned DMEM_WORD_BYTES = 4;
  localparam int unsigned DMEM_DATA_W     = 32;
  localparam int unsigned DMEM_ADDR_W     = 32;
  localparam int unsigned DMEM_CNT_W      = 4;

  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;

  typedef struct packed {
    logic                       write;
    logic [DMEM_ADDR_W-1:0]     addr;
    logic [DMEM_DATA_W-1:0]     wdata;
    logic [DMEM_WORD_BYTES-1:0] wstrb;
  } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned IDX_W       = 10
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       en_i,
  input  logic [DMEM_WORD_BYTES-1:0] we_i,
  input  logic [IDX_W-1:0]           idx_i,
  input  logic [DMEM_DATA_W-1:0]     wdata_i,
  output logic [DMEM_DATA_W-1:0]     rdata_o
);

  logic [DMEM_DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DMEM_DATA_W-1:0] rdata_q;

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clock) begin
    if (en_i) begin
      for (int b = 0; b < int'(DMEM_WORD_BYTES); b++) begin
        if (we_i[b]) mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else if (en_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the core's load/store port: one outstanding request, programmable wait states,
// registered response channel with error reporting for misaligned or out-of-range accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [DMEM_ADDR_W-1:0]     req_addr,
  input  logic [DMEM_DATA_W-1:0]     req_wdata,
  input  logic [DMEM_WORD_BYTES-1:0] req_wstrb,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DMEM_DATA_W-1:0]     rsp_rdata,
  output logic                       rsp_error
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  dmem_state_t             state_q, state_d;
  logic [DMEM_CNT_W-1:0]   cnt_q, cnt_d;
  dmem_req_t               req_q, req_d;
  logic                    err_q, err_d;
  logic                    req_ready_q, req_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DMEM_DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_error_q, rsp_error_d;

  dmem_req_t               cur_req;
  dmem_req_t               acc_req;
  logic                    acc_err;
  logic                    acc_fire;
  logic                    accept;
  logic                    arr_en;
  logic [DMEM_WORD_BYTES-1:0] arr_we;
  logic [DMEM_DATA_W-1:0]  arr_rdata;

  assign cur_req = '{write: req_write, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
  assign accept  = req_valid && req_ready_q;

  // With zero wait states the access is issued straight from the port on the accept edge.
  assign acc_req = (state_q == IDLE) ? cur_req : req_q;
  assign acc_err = (acc_req.addr[1:0] != 2'b00) ||
                   ({2'b00, acc_req.addr[DMEM_ADDR_W-1:2]} >= 32'(DEPTH_WORDS));
  assign arr_en  = acc_fire && !acc_err;
  assign arr_we  = (arr_en && acc_req.write) ? acc_req.wstrb : '0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    acc_fire    = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          req_d = cur_req;
          if (LATENCY == 0) begin
            acc_fire = 1'b1;
            err_d    = acc_err;
            cnt_d    = '0;
            state_d  = RESP;
          end else begin
            cnt_d   = DMEM_CNT_W'(LATENCY);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - DMEM_CNT_W'(1);
        if (cnt_q == DMEM_CNT_W'(1)) begin
          acc_fire = 1'b1;
          err_d    = acc_err;
          state_d  = RESP;
        end
      end
      RESP: begin
        // First RESP cycle latches the registered array output; afterwards hold until taken.
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_error_d = err_q;
          rsp_rdata_d = (req_q.write || err_q) ? '0 : arr_rdata;
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clock   (clock),
    .reset_n (reset_n),
    .en_i    (arr_en),
    .we_i    (arr_we),
    .idx_i   (acc_req.addr[IDX_W+1:2]),
    .wdata_i (acc_req.wdata),
    .rdata_o (arr_rdata)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule
